seg7_digit_scanner: RTL and testbench

Time-multiplexed scan controller for a multi-digit common-segment 7-segment display. It holds a coherent frame of BCD digits and drives them one at a time onto the single BCD-to-7-segment decoder stage that sits directly downstream. It generates that decoder's `d,c,b,a`, `enable` and `seg7all_on` inputs plus the one-hot digit selects. It also handles leading-zero blanking, invalid-digit blanking, lamp test and an anti-ghosting guard interval.

---
 rtl/seg7_digit_scanner_pkg.sv | 20 ++
 rtl/seg7_digit_scanner_scan_timer.sv | 51 +++++
 rtl/seg7_digit_scanner.sv | 145 ++++++++++++++
 tb/tb_seg7_digit_scanner.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/seg7_digit_scanner_pkg.sv
// Shared definitions for the 7-segment digit scanner: scan states,
// the largest legal BCD digit and the counter width helper.
package seg7_digit_scanner_pkg;

    typedef enum logic {
        ST_GUARD = 1'b0,
        ST_DRIVE = 1'b1
    } scan_state_e;

    localparam logic [3:0] BCD_MAX = 4'd9;

    // Bits needed to count 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        if (n <= 2) begin
            return 1;
        end
        return $clog2(n);
    endfunction

endpackage

// File: rtl/seg7_digit_scanner_scan_timer.sv
// Slot counter and digit index for the scanner. The slot counter k runs
// 0..SCAN_DIV-1; each wrap advances the digit index modulo NUM_DIGITS.
module seg7_digit_scanner_scan_timer
    import seg7_digit_scanner_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int GUARD_CYCLES = 500,
    localparam int K_W         = cnt_width(SCAN_DIV),
    localparam int IDX_W       = cnt_width(NUM_DIGITS)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             slot_guard_o,
    output logic             frame_start_o
);

    localparam logic [K_W-1:0]   K_LAST   = K_W'(SCAN_DIV - 1);
    localparam logic [K_W-1:0]   GUARD_K  = K_W'(GUARD_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [K_W-1:0]   k_q, k_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    // Next slot position: wrap k at the slot end and step to the next digit.
    always_comb begin
        k_d   = k_q + K_W'(1);
        idx_d = idx_q;
        if (k_q == K_LAST) begin
            k_d   = '0;
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end
    end

    // Slot position registers; reset restarts scanning at digit 0, cycle 0.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            k_q   <= '0;
            idx_q <= '0;
        end else begin
            k_q   <= k_d;
            idx_q <= idx_d;
        end
    end

    assign idx_o         = idx_q;
    assign slot_guard_o  = (k_q < GUARD_K);
    assign frame_start_o = (k_q == '0) && (idx_q == '0);

endmodule

// File: rtl/seg7_digit_scanner.sv
// Time-multiplexed scan controller for a common-segment 7-segment display.
// Feeds one BCD-to-7-segment decoder with the current digit, its enable and
// lamp-test, and drives the one-hot digit selects.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_GUARD | first GUARD_CYCLES of a slot: no digit selected, decoder off
//   ST_DRIVE | rest of the slot: digit idx selected, nibble driven, enabled
//            | unless blanked (leading zero / invalid) and not lamp-tested
module seg7_digit_scanner
    import seg7_digit_scanner_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int GUARD_CYCLES = 500
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    input  logic                    load,
    input  logic                    lzb_en,
    input  logic                    lamp_test,
    output logic                    d,
    output logic                    c,
    output logic                    b,
    output logic                    a,
    output logic                    enable,
    output logic                    seg7all_on,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic                    frame_tick,
    output logic                    bcd_err
);

    localparam int IDX_W = cnt_width(NUM_DIGITS);

    logic [IDX_W-1:0] idx;
    logic             slot_guard;
    logic             frame_start;

    seg7_digit_scanner_scan_timer #(
        .NUM_DIGITS   (NUM_DIGITS),
        .SCAN_DIV     (SCAN_DIV),
        .GUARD_CYCLES (GUARD_CYCLES)
    ) u_timer (
        .clk_i         (clk),
        .rst_i         (rst),
        .idx_o         (idx),
        .slot_guard_o  (slot_guard),
        .frame_start_o (frame_start)
    );

    logic [4*NUM_DIGITS-1:0] pend_q, pend_d;
    logic [4*NUM_DIGITS-1:0] act_q, act_d;

    logic [NUM_DIGITS-1:0]   digit_sel_q, digit_sel_d;
    logic [3:0]              nib_q, nib_d;
    logic                    enable_q, enable_d;
    logic                    seg7all_on_q;
    logic                    frame_tick_q;
    logic                    bcd_err_q, bcd_err_d;

    scan_state_e             state_d;
    logic [4*NUM_DIGITS-1:0] eff_frame;
    logic [3:0]              cur_nib;
    logic [NUM_DIGITS-1:0]   cur_sel;
    logic                    cur_tail_zero;
    logic                    zero_run;
    logic                    lead_zero;
    logic                    invalid;

    // Frame decode. At a frame start the pending frame is what becomes active,
    // so it is used directly; every digit of a frame then comes from one value
    // even when the guard interval is zero.
    always_comb begin
        pend_d        = load ? bcd_in : pend_q;
        eff_frame     = frame_start ? pend_q : act_q;
        act_d         = eff_frame;
        cur_nib       = '0;
        cur_sel       = '0;
        cur_tail_zero = 1'b0;
        zero_run      = 1'b1;
        bcd_err_d     = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run && (eff_frame[4*i +: 4] == 4'd0);
            if (eff_frame[4*i +: 4] > BCD_MAX) begin
                bcd_err_d = 1'b1;
            end
            if (idx == IDX_W'(i)) begin
                cur_nib       = eff_frame[4*i +: 4];
                cur_sel[i]    = 1'b1;
                cur_tail_zero = zero_run;
            end
        end
        lead_zero = lzb_en && (idx != '0) && cur_tail_zero;
        invalid   = (cur_nib > BCD_MAX);
        state_d   = slot_guard ? ST_GUARD : ST_DRIVE;

        digit_sel_d = '0;
        nib_d       = '0;
        enable_d    = 1'b0;
        if (state_d == ST_DRIVE) begin
            digit_sel_d = cur_sel;
            nib_d       = cur_nib;
            enable_d    = lamp_test || !(lead_zero || invalid);
        end
    end

    // Frame buffers: pending takes loads, active refreshes at each frame start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q <= '0;
            act_q  <= '0;
        end else begin
            pend_q <= pend_d;
            act_q  <= act_d;
        end
    end

    // Registered outputs so the decoder and digit drivers see glitch-free levels.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digit_sel_q  <= '0;
            nib_q        <= '0;
            enable_q     <= 1'b0;
            seg7all_on_q <= 1'b0;
            frame_tick_q <= 1'b0;
            bcd_err_q    <= 1'b0;
        end else begin
            digit_sel_q  <= digit_sel_d;
            nib_q        <= nib_d;
            enable_q     <= enable_d;
            seg7all_on_q <= lamp_test;
            frame_tick_q <= frame_start;
            bcd_err_q    <= bcd_err_d;
        end
    end

    assign {d, c, b, a} = nib_q;
    assign enable       = enable_q;
    assign seg7all_on   = seg7all_on_q;
    assign digit_sel    = digit_sel_q;
    assign frame_tick   = frame_tick_q;
    assign bcd_err      = bcd_err_q;

endmodule

// File: tb/tb_seg7_digit_scanner.sv
// Scoreboard bench for seg7_digit_scanner with NUM_DIGITS=4, SCAN_DIV=8,
// GUARD_CYCLES=2. Stimulus pushes expected per-cycle outputs; a monitor pops
// and compares on the falling edge after the DUT registers them.
module tb_seg7_digit_scanner;

    localparam int N  = 4;
    localparam int SD = 8;
    localparam int G  = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] bcd_in = '0;
    logic        load = 1'b0;
    logic        lzb_en = 1'b0;
    logic        lamp_test = 1'b0;
    logic        d, c, b, a, enable, seg7all_on, frame_tick, bcd_err;
    logic [3:0]  digit_sel;

    seg7_digit_scanner #(
        .NUM_DIGITS   (N),
        .SCAN_DIV     (SD),
        .GUARD_CYCLES (G)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bcd_in     (bcd_in),
        .load       (load),
        .lzb_en     (lzb_en),
        .lamp_test  (lamp_test),
        .d          (d),
        .c          (c),
        .b          (b),
        .a          (a),
        .enable     (enable),
        .seg7all_on (seg7all_on),
        .digit_sel  (digit_sel),
        .frame_tick (frame_tick),
        .bcd_err    (bcd_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [3:0] sel;
        logic [3:0] nib;
        bit         chk_nib;
        logic       en;
        logic       all_on;
        logic       tick;
        logic       err;
        string      tag;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    int   ecount;

    // Edges since reset release; after edge e the monitor sees ecount == e+1.
    always @(posedge clk or posedge rst) begin
        if (rst) ecount <= 0;
        else     ecount <= ecount + 1;
    end

    task automatic check_vec(input string tag, input int cyc, input logic [11:0] got,
                             input logic [11:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got sel/nib/en/all/tick/err=%b_%b_%b_%b_%b_%b expected=%b_%b_%b_%b_%b_%b",
                     tag, cyc, got[11:8], got[7:4], got[3], got[2], got[1], got[0],
                     exp[11:8], exp[7:4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    // Monitor: compare every expected entry due for the current output cycle.
    always @(negedge clk) begin
        exp_t x;
        logic [11:0] got, exp;
        if (!rst) begin
            while (sbq.size() > 0 && sbq[0].cyc <= ecount - 1) begin
                x = sbq.pop_front();
                got = {digit_sel, (x.chk_nib ? {d, c, b, a} : 4'h0), enable, seg7all_on,
                       frame_tick, bcd_err};
                exp = {x.sel, (x.chk_nib ? x.nib : 4'h0), x.en, x.all_on, x.tick, x.err};
                if (x.cyc != ecount - 1) begin
                    x.tag = {x.tag, "_stale"};
                    exp = ~got;
                end
                check_vec(x.tag, x.cyc, got, exp);
            end
        end
    end

    // Reference: output cycle e shows slot cycle e%SD of digit (e/SD)%N.
    function automatic exp_t model(input int e, input logic [15:0] act, input bit lzb,
                                   input bit lamp);
        exp_t x;
        int   k, idx;
        logic [3:0] nb;
        bit   guard, lz, bad;
        k     = e % SD;
        idx   = (e / SD) % N;
        guard = (k < G);
        nb    = act[idx*4 +: 4];
        lz    = lzb && (idx != 0) && ((act >> (idx*4)) == 16'h0);
        bad   = (nb > 4'd9);
        x.cyc     = e;
        x.sel     = guard ? 4'b0000 : 4'(1 << idx);
        x.nib     = nb;
        x.chk_nib = !guard;
        x.en      = !guard && (lamp || !(lz || bad));
        x.all_on  = lamp;
        x.tick    = ((e % (SD*N)) == 0);
        x.err     = (act[3:0] > 9) || (act[7:4] > 9) || (act[11:8] > 9) || (act[15:12] > 9);
        x.tag     = "model";
        return x;
    endfunction

    task automatic push_hand(input int e, input logic [3:0] sel, input logic [3:0] nib,
                             input bit chk_nib, input logic en, input logic all_on,
                             input logic tick, input logic err, input string tag);
        exp_t x;
        x.cyc = e; x.sel = sel; x.nib = nib; x.chk_nib = chk_nib; x.en = en;
        x.all_on = all_on; x.tick = tick; x.err = err; x.tag = tag;
        sbq.push_back(x);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    logic [15:0] pend_m, act_m;

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_vec("reset_init", 0, {digit_sel, d, c, b, a, enable, seg7all_on, frame_tick, bcd_err}, 12'h000);
        rst = 1'b0;
        pend_m = '0;
        act_m  = '0;
        for (int e = 0; e <= 213; e++) begin
            load = 1'b0;
            case (e)
                13:  begin load = 1'b1; bcd_in = 16'h1234; end
                45:  begin load = 1'b1; bcd_in = 16'h0050; end
                96:  begin load = 1'b1; bcd_in = 16'h00A3; end
                140: begin load = 1'b1; bcd_in = 16'h0000; end
                default: ;
            endcase
            lzb_en    = ((e >= 64) && (e < 96)) || (e >= 160);
            lamp_test = (e >= 160);
            if (e % (SD*N) == 0) act_m = pend_m;
            if (load) pend_m = bcd_in;
            sbq.push_back(model(e, act_m, lzb_en, lamp_test));
            case (e)
                0:   push_hand(e, 4'b0000, 4'h0, 0, 0, 0, 1, 0, "tick_first");
                26:  push_hand(e, 4'b1000, 4'h0, 1, 1, 0, 0, 0, "f0_still_zero");
                34:  push_hand(e, 4'b0001, 4'h4, 1, 1, 0, 0, 0, "f1_digit0");
                63:  push_hand(e, 4'b1000, 4'h1, 1, 1, 0, 0, 0, "f1_digit3");
                74:  push_hand(e, 4'b0010, 4'h5, 1, 1, 0, 0, 0, "lzb_digit1");
                83:  push_hand(e, 4'b0100, 4'h0, 1, 0, 0, 0, 0, "lzb_digit2");
                90:  push_hand(e, 4'b1000, 4'h0, 1, 0, 0, 0, 0, "lzb_digit3");
                98:  push_hand(e, 4'b0001, 4'h0, 1, 1, 0, 0, 0, "nolzb_digit0");
                122: push_hand(e, 4'b1000, 4'h0, 1, 1, 0, 0, 0, "nolzb_digit3");
                128: push_hand(e, 4'b0000, 4'h0, 0, 0, 0, 1, 1, "err_frame_start");
                138: push_hand(e, 4'b0010, 4'hA, 1, 0, 0, 0, 1, "invalid_digit1");
                160: push_hand(e, 4'b0000, 4'h0, 0, 0, 1, 1, 0, "lamp_guard");
                186: push_hand(e, 4'b1000, 4'h0, 1, 1, 1, 0, 0, "lamp_digit3");
                default: ;
            endcase
            @(negedge clk);
        end

        // Outputs now show slot cycle 5 of digit 2; reset must clear them at once.
        #1 rst = 1'b1;
        #1;
        check_vec("reset_async", 213, {digit_sel, d, c, b, a, enable, seg7all_on, frame_tick, bcd_err}, 12'h000);
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL sb_drain_before_reset got=%0d entries expected=0", sbq.size());
        end
        sbq.delete();
        load = 1'b0; lzb_en = 1'b0; lamp_test = 1'b0; bcd_in = 16'hFFFF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        pend_m = '0;
        act_m  = '0;
        for (int e = 0; e < 40; e++) begin
            if (e % (SD*N) == 0) act_m = pend_m;
            sbq.push_back(model(e, act_m, 1'b0, 1'b0));
            case (e)
                0:  push_hand(e, 4'b0000, 4'h0, 0, 0, 0, 1, 0, "rst_tick_first");
                1:  push_hand(e, 4'b0000, 4'h0, 0, 0, 0, 0, 0, "rst_guard");
                2:  push_hand(e, 4'b0001, 4'h0, 1, 1, 0, 0, 0, "rst_digit0_zero");
                32: push_hand(e, 4'b0000, 4'h0, 0, 0, 0, 1, 0, "rst_tick_second");
                default: ;
            endcase
            @(negedge clk);
        end
        @(negedge clk);
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL sb_drain_end got=%0d entries expected=0", sbq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
